// File: rtl/joy_pkg.sv
// Shared definitions for the DB15 joystick link.
//   JB_*       : bit positions inside a player's button word
//   joytx_state_t : transmitter shift-chain states
//   frame_len  : number of bits in one two-player frame
package joy_pkg;

  localparam int unsigned JB_R  = 0;
  localparam int unsigned JB_L  = 1;
  localparam int unsigned JB_D  = 2;
  localparam int unsigned JB_U  = 3;
  localparam int unsigned JB_F1 = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    SHIFT  = 2'd2
  } joytx_state_t;

  function automatic int unsigned frame_len(input int unsigned bpp);
    return 2 * bpp;
  endfunction

endpackage

// File: rtl/joy_sync_edge.sv
// Multi-stage synchroniser for an asynchronous link input, with edge pulses.
// The chain and the edge reference reset to 1 (idle level of the link lines).
//   clk, reset_n : system clock, async active-low reset
//   din          : asynchronous input
//   level        : synchronised level
//   rise / fall  : one-clk pulses on synchronised rising / falling edges
module joy_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = chain[STAGES-1] & ~prev;
  assign fall  = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick link, controller side: parallel-in/serial-out shift chain.
// A (synchronised) low on joy_load captures {joy2, joy1}; each joy_clk rising
// edge then shifts one bit out on joy_data (active-low), joy1 bit0 first.
//   clk, reset_n : system clock, async active-low reset
//   joy1, joy2   : player button words, active-high
//   joy_clk      : shift clock from the reader (async)
//   joy_load     : parallel load from the reader, active-low (async)
//   joy_data     : serial data out, active-low
//   busy         : frame captured and not yet fully shifted
//   frame_done   : one-clk pulse once the last bit has been shifted past
//   link_ok      : reader activity seen recently (tied 1 without watchdog)
// Optional feature macro: JOYTX_WDOG_EN enables the link watchdog.
module joy_db15_tx
  import joy_pkg::*;
#(
  parameter int unsigned BITS_PER_PLAYER = 12,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned WDOG_CYCLES     = 4194304
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [BITS_PER_PLAYER-1:0] joy1,
  input  logic [BITS_PER_PLAYER-1:0] joy2,
  input  logic                       joy_clk,
  input  logic                       joy_load,
  output logic                       joy_data,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       link_ok
);

  localparam int unsigned FRAME = frame_len(BITS_PER_PLAYER);
  localparam int unsigned CW    = $clog2(FRAME + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME);

  logic clk_lvl, clk_rise, clk_fall;
  logic load_lvl, load_rise, load_fall;
  logic wdog_hit;

  joy_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (joy_clk),
    .level   (clk_lvl),
    .rise    (clk_rise),
    .fall    (clk_fall)
  );

  joy_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_load (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (joy_load),
    .level   (load_lvl),
    .rise    (load_rise),
    .fall    (load_fall)
  );

`ifdef JOYTX_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_MAX  = WW'(WDOG_CYCLES);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

  logic [WW-1:0] wdog_cnt;
  logic          unused_edges;

  // Hit fires on the clk where the counter reaches WDOG_CYCLES.
  assign wdog_hit     = (wdog_cnt == WDOG_LAST) && !load_fall;
  assign unused_edges = ^{clk_lvl, clk_fall, load_rise};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt <= '0;
      link_ok  <= 1'b0;
    end else if (load_fall) begin
      wdog_cnt <= '0;
      link_ok  <= 1'b1;
    end else begin
      if (wdog_cnt != WDOG_MAX) wdog_cnt <= wdog_cnt + WW'(1);
      if (wdog_hit)             link_ok  <= 1'b0;
    end
  end
`else
  logic unused_edges;

  assign wdog_hit     = 1'b0;
  assign link_ok      = 1'b1;
  assign unused_edges = ^{clk_lvl, clk_fall, load_rise, load_fall, WDOG_CYCLES[0]};
`endif

  joytx_state_t          state;
  logic [FRAME-1:0]      shreg;
  logic [CW-1:0]         cnt;

  // Load level has priority over shift edges; joy_data always lags the
  // shift register by one clk so output timing is identical in every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      joy_data   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (wdog_hit) begin
        state    <= IDLE;
        busy     <= 1'b0;
        joy_data <= 1'b1;
      end else if (!load_lvl) begin
        shreg    <= {joy2, joy1};
        cnt      <= '0;
        busy     <= 1'b1;
        state    <= LOADED;
        joy_data <= (state == IDLE) ? 1'b1 : ~shreg[0];
      end else begin
        case (state)
          IDLE: joy_data <= 1'b1;
          LOADED, SHIFT: begin
            if (cnt == CNT_LAST) begin
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              joy_data   <= 1'b1;
            end else begin
              joy_data <= ~shreg[0];
              if (clk_rise) begin
                shreg <= shreg >> 1;
                cnt   <= cnt + CW'(1);
                state <= SHIFT;
              end
            end
          end
          default: begin
            state    <= IDLE;
            joy_data <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_joy_db15_tx.sv
module tb_joy_db15_tx;

  localparam int unsigned BPP   = 12;
  localparam int unsigned FRAME = 2 * BPP;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [BPP-1:0] joy1, joy2;
  logic           joy_clk, joy_load;
  logic           joy_data, busy, frame_done, link_ok;

  int tests_run    = 0;
  int tests_failed = 0;
  int fd_seen      = 0;
  int fd_exp       = 0;

  // Behavioural model: a captured frame and how many bits have gone by.
  logic [FRAME-1:0] m_frame;
  int               m_pos;
  bit               m_active;

`ifdef JOYTX_WDOG_EN
  localparam logic EXP_LINK_RST = 1'b0;
`else
  localparam logic EXP_LINK_RST = 1'b1;
`endif

  joy_db15_tx #(
    .BITS_PER_PLAYER (BPP),
    .SYNC_STAGES     (2),
    .WDOG_CYCLES     (100)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .joy1       (joy1),
    .joy2       (joy2),
    .joy_clk    (joy_clk),
    .joy_load   (joy_load),
    .joy_data   (joy_data),
    .busy       (busy),
    .frame_done (frame_done),
    .link_ok    (link_ok)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_seen++;

  typedef struct {
    logic [BPP-1:0] j1;
    logic [BPP-1:0] j2;
    int             edges;
    logic           exp_data;
    logic           exp_busy;
  } vec_t;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_data();
    return m_active ? ~m_frame[m_pos] : 1'b1;
  endfunction

  task automatic do_load();
    joy_load = 1'b0;
    tick(3);
    joy_load = 1'b1;
    m_frame  = {joy2, joy1};
    m_pos    = 0;
    m_active = 1'b1;
    tick(4);
  endtask

  task automatic do_edge();
    joy_clk = 1'b1;
    tick(3);
    joy_clk = 1'b0;
    tick(3);
    if (m_active) begin
      m_pos++;
      if (m_pos == FRAME) begin
        m_active = 1'b0;
        fd_exp++;
      end
    end
  endtask

  task automatic check_state(input string name);
    check({name, "_data"}, {31'd0, joy_data}, {31'd0, exp_data()});
    check({name, "_busy"}, {31'd0, busy}, {31'd0, m_active});
  endtask

  vec_t vecs[9];

  initial begin
    int base;
    int n;
    vecs[0] = '{12'h015, 12'h800, 0,  1'b0, 1'b1};
    vecs[1] = '{12'h015, 12'h800, 1,  1'b1, 1'b1};
    vecs[2] = '{12'h015, 12'h800, 23, 1'b0, 1'b1};
    vecs[3] = '{12'h015, 12'h800, 24, 1'b1, 1'b0};
    vecs[4] = '{12'hFFF, 12'h000, 11, 1'b0, 1'b1};
    vecs[5] = '{12'hFFF, 12'h000, 12, 1'b1, 1'b1};
    vecs[6] = '{12'h000, 12'h001, 12, 1'b0, 1'b1};
    vecs[7] = '{12'hA5A, 12'h000, 5,  1'b1, 1'b1};
    vecs[8] = '{12'hA5A, 12'h000, 6,  1'b0, 1'b1};

    m_active = 1'b0;
    m_pos    = 0;
    m_frame  = '0;
    reset_n  = 1'b0;
    joy_clk  = 1'b0;
    joy_load = 1'b1;
    joy1     = '0;
    joy2     = '0;
    tick(3);
    check("rst_data", {31'd0, joy_data}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_link", {31'd0, link_ok}, {31'd0, EXP_LINK_RST});
    reset_n = 1'b1;
    tick(5);
    check("idle_data", {31'd0, joy_data}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);

`ifdef JOYTX_WDOG_EN
    begin
      int high_cnt;
      int base_fd;
      bit fell;
      high_cnt = 0;
      fell     = 1'b0;
      base_fd  = fd_seen;
      joy_load = 1'b0;
      for (int i = 0; i < 300 && !fell; i++) begin
        @(negedge clk);
        if (i == 3) joy_load = 1'b1;
        if (i == 50) check("wdog_busy_mid", {31'd0, busy}, 32'd1);
        if (link_ok === 1'b1) high_cnt++;
        else if (high_cnt > 0) fell = 1'b1;
      end
      check("wdog_fell", {31'd0, fell}, 32'd1);
      check("wdog_high_cycles", high_cnt, 100);
      check("wdog_busy_after", {31'd0, busy}, 32'd0);
      check("wdog_data_after", {31'd0, joy_data}, 32'd1);
      tick(3);
      check("wdog_no_done", fd_seen, base_fd);
    end
`else
    // Clock edges with no load are ignored.
    for (int i = 0; i < 5; i++) do_edge();
    check("idle_edges_data", {31'd0, joy_data}, 32'd1);
    check("idle_edges_done", fd_seen, 0);

    // Frame content, every bit.
    joy1 = 12'h015;
    joy2 = 12'h800;
    do_load();
    check_state("frame_b0");
    for (int i = 1; i <= FRAME; i++) begin
      do_edge();
      check_state($sformatf("frame_b%0d", i));
    end
    check("frame_done_cnt", fd_seen, fd_exp);

    // Load coincident with a clock edge after 3 shifts.
    joy1 = 12'h3C9;
    joy2 = 12'h5A6;
    do_load();
    for (int i = 0; i < 3; i++) do_edge();
    check_state("coin_pre");
    joy_load = 1'b0;
    joy_clk  = 1'b1;
    tick(3);
    joy_load = 1'b1;
    m_frame  = {joy2, joy1};
    m_pos    = 0;
    m_active = 1'b1;
    tick(4);
    joy_clk = 1'b0;
    tick(3);
    check_state("coin_b0");
    base = fd_seen;
    for (int i = 1; i <= FRAME; i++) begin
      do_edge();
      if (i == FRAME - 1) check("coin_no_early_done", fd_seen, base);
      check_state($sformatf("coin_b%0d", i));
    end
    check("coin_done_cnt", fd_seen, fd_exp);

    // Mid-frame abort with all-pressed player 1.
    joy1 = 12'h0F0;
    joy2 = 12'h00F;
    do_load();
    for (int i = 0; i < 10; i++) do_edge();
    base = fd_seen;
    joy1 = 12'hFFF;
    do_load();
    check("abort_b0", {31'd0, joy_data}, 32'd0);
    for (int i = 1; i < BPP; i++) begin
      do_edge();
      check($sformatf("abort_b%0d", i), {31'd0, joy_data}, 32'd0);
    end
    do_edge();
    check("abort_no_done", fd_seen, base);
    for (int i = BPP + 1; i <= FRAME; i++) do_edge();
    check("abort_done_once", fd_seen, base + 1);

    // Async reset mid-frame.
    joy1 = 12'h001;
    joy2 = 12'h000;
    do_load();
    for (int i = 0; i < 7; i++) do_edge();
    #3 reset_n = 1'b0;
    #1;
    check("arst_data", {31'd0, joy_data}, 32'd1);
    check("arst_busy", {31'd0, busy}, 32'd0);
    m_active = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    for (int i = 0; i < 3; i++) do_edge();
    check("arst_after_data", {31'd0, joy_data}, 32'd1);
    check("arst_after_busy", {31'd0, busy}, 32'd0);

    // Vector table.
    foreach (vecs[k]) begin
      joy1 = vecs[k].j1;
      joy2 = vecs[k].j2;
      do_load();
      for (int i = 0; i < vecs[k].edges; i++) do_edge();
      check($sformatf("vec%0d_data", k), {31'd0, joy_data}, {31'd0, vecs[k].exp_data});
      check($sformatf("vec%0d_busy", k), {31'd0, busy}, {31'd0, vecs[k].exp_busy});
    end
    check("vec_done_cnt", fd_seen, fd_exp);

    // Random frames; inputs may change after capture.
    for (int r = 0; r < 25; r++) begin
      joy1 = BPP'($urandom);
      joy2 = BPP'($urandom);
      do_load();
      if ($urandom_range(0, 1) == 1) begin
        joy1 = BPP'($urandom);
        joy2 = BPP'($urandom);
      end
      n = $urandom_range(0, FRAME);
      check_state($sformatf("rnd%0d_b0", r));
      for (int i = 1; i <= n; i++) begin
        do_edge();
        check_state($sformatf("rnd%0d_b%0d", r, i));
      end
    end
    tick(3);
    check("rnd_done_cnt", fd_seen, fd_exp);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
